// File: rtl/wt_cache_ctrl_fsm_pkg.sv
// Shared types and constants for the write-through cache controller FSM.
package wt_cache_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRdLook = 3'd1,
    StFill   = 3'd2,
    StWrLook = 3'd3,
    StWrThru = 3'd4
  } state_e;

  // {refill, update} cache op codes
  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b11;

  // Word index needs at least one bit even for single-word blocks.
  function automatic int unsigned idx_width(input int unsigned off_w);
    return (off_w == 0) ? 1 : off_w;
  endfunction

endpackage

// File: rtl/wt_cache_ctrl_fsm_if.sv
// CPU request / cache op / main-memory signals of the cache controller.
interface wt_cache_ctrl_fsm_if #(
  parameter int unsigned IdxW = 2
);
  logic            mem_read;
  logic            mem_write;
  logic            hit;
  logic            ready;
  logic            stall;
  logic            main_read;
  logic            main_write;
  logic            refill;
  logic            update;
  logic [IdxW-1:0] word_idx;
  logic            err;
  logic            req_err;

  modport master (
    input  mem_read, mem_write, hit, ready,
    output stall, main_read, main_write, refill, update, word_idx, err, req_err
  );

  modport slave (
    output mem_read, mem_write, hit, ready,
    input  stall, main_read, main_write, refill, update, word_idx, err, req_err
  );
endinterface

// File: rtl/wt_cache_ctrl_fsm_mem_watchdog.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry.
module wt_cache_ctrl_fsm_mem_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam bit              Enable = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] Limit  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = Enable && tick && !clr && (cnt_q == Limit);

endmodule

// File: rtl/wt_cache_ctrl_fsm.sv
// Write-through direct-mapped cache controller with block refill, optional
// write-allocate, memory watchdog and illegal-request detection.
module wt_cache_ctrl_fsm
  import wt_cache_ctrl_fsm_pkg::*;
#(
  parameter int unsigned WORD_OFF_W     = 2,
  parameter int unsigned WRITE_ALLOCATE = 0,
  parameter int unsigned TIMEOUT        = 255,
  parameter int unsigned TO_W           = 8
) (
  input logic                 clk,
  input logic                 reset,
  wt_cache_ctrl_fsm_if.master bus
);

  localparam int unsigned     IdxW    = idx_width(WORD_OFF_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'((1 << WORD_OFF_W) - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] word_idx_q, word_idx_d;
  logic            hit_q, hit_d;
  logic            fill_done_q, fill_done_d;
  logic            ret_wr_q, ret_wr_d;

  logic       stall, main_read, main_write, err, req_err;
  logic [1:0] op;
  logic       in_mem, wd_expire;

  assign in_mem = (state_q == StFill) || (state_q == StWrThru);

  wt_cache_ctrl_fsm_mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_mem || bus.ready),
    .tick   (in_mem && !bus.ready),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    hit_d       = hit_q;
    fill_done_d = fill_done_q;
    ret_wr_d    = ret_wr_q;
    stall       = 1'b0;
    main_read   = 1'b0;
    main_write  = 1'b0;
    op          = OpNone;
    err         = 1'b0;
    req_err     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.mem_read && !bus.mem_write) begin
          state_d     = StRdLook;
          fill_done_d = 1'b0;
        end else if (bus.mem_write && !bus.mem_read) begin
          state_d     = StWrLook;
          fill_done_d = 1'b0;
        end else if (bus.mem_read && bus.mem_write) begin
          req_err = 1'b1;
        end
      end
      StRdLook: begin
        if (bus.hit) begin
          op      = OpRead;
          state_d = StIdle;
        end else if (!fill_done_q) begin
          stall      = 1'b1;
          word_idx_d = '0;
          ret_wr_d   = 1'b0;
          state_d    = StFill;
        end else begin
          // Block was just refilled yet still misses: give up.
          stall   = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StFill: begin
        stall     = 1'b1;
        main_read = 1'b1;
        if (bus.ready) begin
          op = OpWrite;
          if (word_idx_q == LastIdx) begin
            fill_done_d = 1'b1;
            word_idx_d  = '0;
            state_d     = ret_wr_q ? StWrLook : StRdLook;
          end else begin
            word_idx_d = word_idx_q + IdxW'(1);
          end
        end else if (wd_expire) begin
          stall      = 1'b0;
          err        = 1'b1;
          word_idx_d = '0;
          state_d    = StIdle;
        end
      end
      StWrLook: begin
        stall = 1'b1;
        hit_d = bus.hit;
        if (bus.hit || (WRITE_ALLOCATE == 0)) begin
          state_d = StWrThru;
        end else if (!fill_done_q) begin
          ret_wr_d   = 1'b1;
          word_idx_d = '0;
          state_d    = StFill;
        end else begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StWrThru: begin
        stall      = 1'b1;
        main_write = 1'b1;
        if (bus.ready) begin
          // Cache is written only on a hit, together with the memory accept.
          op      = hit_q ? OpWrite : OpNone;
          stall   = 1'b0;
          state_d = StIdle;
        end else if (wd_expire) begin
          stall      = 1'b0;
          err        = 1'b1;
          word_idx_d = '0;
          state_d    = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      hit_q       <= 1'b0;
      fill_done_q <= 1'b0;
      ret_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      hit_q       <= hit_d;
      fill_done_q <= fill_done_d;
      ret_wr_q    <= ret_wr_d;
    end
  end

  assign bus.stall      = stall;
  assign bus.main_read  = main_read;
  assign bus.main_write = main_write;
  assign bus.refill     = op[1];
  assign bus.update     = op[0];
  assign bus.word_idx   = word_idx_q;
  assign bus.err        = err;
  assign bus.req_err    = req_err;

endmodule

// File: tb/tb_wt_cache_ctrl_fsm.sv
// Scoreboard bench: dut_a is write-around with TIMEOUT=8, dut_b is
// write-allocate with the watchdog disabled; both use 4-word blocks.
module tb_wt_cache_ctrl_fsm;

  localparam int DutA = 0;
  localparam int DutB = 1;

  typedef struct {
    int         dut;
    string      name;
    logic [8:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  wt_cache_ctrl_fsm_if #(.IdxW(2)) bus_a ();
  wt_cache_ctrl_fsm_if #(.IdxW(2)) bus_b ();

  wt_cache_ctrl_fsm #(
    .WORD_OFF_W     (2),
    .WRITE_ALLOCATE (0),
    .TIMEOUT        (8),
    .TO_W           (8)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  wt_cache_ctrl_fsm #(
    .WORD_OFF_W     (2),
    .WRITE_ALLOCATE (1),
    .TIMEOUT        (0),
    .TO_W           (8)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  // Packed as {stall, main_read, main_write, refill, update, word_idx, err, req_err}
  logic [8:0] out_a, out_b;
  assign out_a = {bus_a.stall, bus_a.main_read, bus_a.main_write, bus_a.refill, bus_a.update,
                  bus_a.word_idx, bus_a.err, bus_a.req_err};
  assign out_b = {bus_b.stall, bus_b.main_read, bus_b.main_write, bus_b.refill, bus_b.update,
                  bus_b.word_idx, bus_b.err, bus_b.req_err};

  function automatic logic [8:0] o(input logic s, mr, mw, rf, up, input int ix,
                                   input logic er, rq);
    return {s, mr, mw, rf, up, 2'(ix), er, rq};
  endfunction

  task automatic step(input int d, input logic rn, rd, wr, h, rdy, input logic [8:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    if (d == DutA) begin
      rst_a = rn; bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.hit = h; bus_a.ready = rdy;
    end else begin
      rst_b = rn; bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.hit = h; bus_b.ready = rdy;
    end
    exp_q.push_back('{dut: d, name: nm, exp: e});
  endtask

  always @(negedge clk) begin : monitor
    exp_t       x;
    logic [8:0] got;
    if (exp_q.size() > 0) begin
      x   = exp_q.pop_front();
      got = (x.dut == DutA) ? out_a : out_b;
      total++;
      if (got === x.exp) begin
        passed++;
      end else begin
        $display("FAIL %s (dut %0d): got %b required %b", x.name, x.dut, got, x.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0; bus_a.hit = 1'b0; bus_a.ready = 1'b0;
    bus_b.mem_read = 1'b0; bus_b.mem_write = 1'b0; bus_b.hit = 1'b0; bus_b.ready = 1'b0;

    step(DutA, 0, 0, 0, 0, 0, '0, "reset_a");
    step(DutB, 0, 0, 0, 0, 0, '0, "reset_b");
    step(DutA, 1, 0, 0, 0, 0, '0, "idle_a");
    step(DutB, 1, 0, 0, 0, 0, '0, "idle_b");

    // Read hit
    step(DutA, 1, 1, 0, 1, 0, '0, "rh_idle");
    step(DutA, 1, 1, 0, 1, 0, o(0, 0, 0, 1, 1, 0, 0, 0), "rh_op11");
    step(DutA, 1, 0, 0, 0, 0, '0, "rh_back_idle");

    // Read miss with ready on alternating cycles
    step(DutA, 1, 1, 0, 0, 0, '0, "rm_idle");
    step(DutA, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "rm_look");
    for (int i = 0; i < 8; i++) begin
      step(DutA, 1, 1, 0, 0, (i % 2 == 1), o(1, 1, 0, 0, (i % 2 == 1), i / 2, 0, 0), "rm_fill");
    end
    step(DutA, 1, 1, 0, 1, 0, o(0, 0, 0, 1, 1, 0, 0, 0), "rm_relook_hit");
    step(DutA, 1, 0, 0, 0, 0, '0, "rm_back_idle");

    // Write hit, ready on the third write-through cycle
    step(DutA, 1, 0, 1, 1, 0, '0, "wh_idle");
    step(DutA, 1, 0, 1, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "wh_look");
    step(DutA, 1, 0, 1, 1, 0, o(1, 0, 1, 0, 0, 0, 0, 0), "wh_thru1");
    step(DutA, 1, 0, 1, 1, 0, o(1, 0, 1, 0, 0, 0, 0, 0), "wh_thru2");
    step(DutA, 1, 0, 1, 1, 1, o(0, 0, 1, 0, 1, 0, 0, 0), "wh_thru3");
    step(DutA, 1, 0, 0, 0, 0, '0, "wh_back_idle");

    // Write miss, write-around: no refill, no cache write
    step(DutA, 1, 0, 1, 0, 0, '0, "wa_idle");
    step(DutA, 1, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "wa_look");
    step(DutA, 1, 0, 1, 0, 1, o(0, 0, 1, 0, 0, 0, 0, 0), "wa_thru");
    step(DutA, 1, 0, 0, 0, 0, '0, "wa_back_idle");

    // Timeout after one word: err on 8th not-ready cycle, word_idx cleared
    step(DutA, 1, 1, 0, 0, 0, '0, "to_idle");
    step(DutA, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "to_look");
    step(DutA, 1, 1, 0, 0, 1, o(1, 1, 0, 0, 1, 0, 0, 0), "to_word0");
    for (int i = 0; i < 7; i++) begin
      step(DutA, 1, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 1, 0, 0), "to_wait");
    end
    step(DutA, 1, 1, 0, 0, 0, o(0, 1, 0, 0, 0, 1, 1, 0), "to_expire");
    step(DutA, 1, 0, 0, 0, 0, '0, "to_after_idle");

    // Ready on the would-be timeout cycle wins; then post-fill miss errors
    step(DutA, 1, 1, 0, 0, 0, '0, "rw_idle");
    step(DutA, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "rw_look");
    for (int i = 0; i < 7; i++) begin
      step(DutA, 1, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0), "rw_wait");
    end
    step(DutA, 1, 1, 0, 0, 1, o(1, 1, 0, 0, 1, 0, 0, 0), "rw_ready_wins");
    for (int i = 1; i < 4; i++) begin
      step(DutA, 1, 1, 0, 0, 1, o(1, 1, 0, 0, 1, i, 0, 0), "rw_fill");
    end
    step(DutA, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 1, 0), "post_fill_miss");
    step(DutA, 1, 0, 0, 0, 0, '0, "pf_back_idle");

    // Illegal request
    step(DutA, 1, 1, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 1), "req_err");
    step(DutA, 1, 0, 0, 0, 0, '0, "req_err_stay_idle");

    // Write miss with allocate: fill, relook hit, write-through
    step(DutB, 1, 0, 1, 0, 0, '0, "wal_idle");
    step(DutB, 1, 0, 1, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "wal_look");
    for (int i = 0; i < 4; i++) begin
      step(DutB, 1, 0, 1, 0, 1, o(1, 1, 0, 0, 1, i, 0, 0), "wal_fill");
    end
    step(DutB, 1, 0, 1, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "wal_relook");
    step(DutB, 1, 0, 1, 1, 1, o(0, 0, 1, 0, 1, 0, 0, 0), "wal_thru");
    step(DutB, 1, 0, 0, 0, 0, '0, "wal_back_idle");

    // Watchdog disabled: long stall without err, then reset at word_idx=2
    step(DutB, 1, 1, 0, 0, 0, '0, "nto_idle");
    step(DutB, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0), "nto_look");
    for (int i = 0; i < 20; i++) begin
      step(DutB, 1, 1, 0, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0), "nto_wait");
    end
    step(DutB, 1, 1, 0, 0, 1, o(1, 1, 0, 0, 1, 0, 0, 0), "nto_word0");
    step(DutB, 1, 1, 0, 0, 1, o(1, 1, 0, 0, 1, 1, 0, 0), "nto_word1");
    step(DutB, 0, 0, 0, 0, 0, '0, "rst_mid_burst");
    step(DutB, 1, 0, 0, 0, 0, '0, "rst_release");

    @(posedge clk);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
